spgd_sequencer: RTL and testbench

Parametrised successor to the SPGD iteration state machine. Sequences one stochastic-parallel-gradient-descent iteration per trigger: DAC select, J+ capture, J− capture, math wait, U write. Adds runtime phase lengths, a free-run mode, an iteration limit with DONE, trigger edge detection and an overrun flag. Sits between the trigger/ADC front end and the J-register/math/DAC-mux datapath on the ADC_CLK domain.

---
 rtl/spgd_sequencer_if.sv | 34 +++
 rtl/spgd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_spgd_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spgd_sequencer_if.sv
// Bus between the SPGD sequencer and its trigger/ADC front end and datapath.
// The master drives the control inputs; the slave is the sequencer itself.
interface spgd_sequencer_if #(
    parameter int CNT_WIDTH  = 16,
    parameter int ITER_WIDTH = 16
);
    logic                  START;
    logic                  FREE_RUN;
    logic                  TRIG_IN;
    logic [CNT_WIDTH-1:0]  PHASE_A_LEN;
    logic [CNT_WIDTH-1:0]  PHASE_B_LEN;
    logic [ITER_WIDTH-1:0] ITER_LIMIT;
    logic                  FSM_JP_WRT;
    logic                  FSM_JM_WRT;
    logic                  FSM_U_WRT;
    logic [1:0]            FSM_DAC_SEL;
    logic [2:0]            FSM_STATE;
    logic [ITER_WIDTH-1:0] ITER_COUNT;
    logic                  BUSY;
    logic                  DONE;
    logic                  OVERRUN;

    modport master (
        output START, FREE_RUN, TRIG_IN, PHASE_A_LEN, PHASE_B_LEN, ITER_LIMIT,
        input  FSM_JP_WRT, FSM_JM_WRT, FSM_U_WRT, FSM_DAC_SEL, FSM_STATE,
               ITER_COUNT, BUSY, DONE, OVERRUN
    );

    modport slave (
        input  START, FREE_RUN, TRIG_IN, PHASE_A_LEN, PHASE_B_LEN, ITER_LIMIT,
        output FSM_JP_WRT, FSM_JM_WRT, FSM_U_WRT, FSM_DAC_SEL, FSM_STATE,
               ITER_COUNT, BUSY, DONE, OVERRUN
    );
endinterface

// File: rtl/spgd_sequencer.sv
// SPGD iteration sequencer: DAC select, J+ capture, J- capture, math wait, U write,
// with runtime phase lengths, free-run, iteration limit and trigger overrun detection.
module spgd_sequencer #(
    parameter int CNT_WIDTH       = 16,
    parameter int ITER_WIDTH      = 16,
    parameter int MATH_WAIT_VALUE = 5
) (
    input  logic               ADC_CLK,
    input  logic               RST_N,
    spgd_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG_WAIT = 3'd1,
        S_PHASE_A   = 3'd2,
        S_JP_WRT    = 3'd3,
        S_PHASE_B   = 3'd4,
        S_JM_WRT    = 3'd5,
        S_MATH      = 3'd6,
        S_U_WRT     = 3'd7
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  MATH_LOAD = CNT_WIDTH'(MATH_WAIT_VALUE - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_ZERO = {ITER_WIDTH{1'b0}};
    localparam logic [ITER_WIDTH-1:0] ITER_ONE  = {{(ITER_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_nxt_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_nxt_cnt;
    logic [CNT_WIDTH-1:0]  r_len_b;
    logic [ITER_WIDTH-1:0] r_iter;
    logic [ITER_WIDTH-1:0] w_nxt_iter;
    logic [ITER_WIDTH-1:0] w_iter_inc;
    logic                  r_done;
    logic                  w_nxt_done;
    logic                  r_ovr;
    logic                  w_nxt_ovr;
    logic                  r_trig_d;
    logic                  w_trig_edge;
    logic                  w_launch;
    logic                  r_jp;
    logic                  r_jm;
    logic                  r_u;
    logic                  r_busy;
    logic [1:0]            r_dac;

    function automatic logic [1:0] dac_sel(input state_t s);
        case (s)
            S_IDLE:              dac_sel = 2'b00;
            S_TRIG_WAIT:         dac_sel = 2'b11;
            S_PHASE_A, S_JP_WRT: dac_sel = 2'b01;
            default:             dac_sel = 2'b10;
        endcase
    endfunction

    assign w_trig_edge = bus.TRIG_IN & ~r_trig_d;
    assign w_iter_inc  = r_iter + ITER_ONE;

    // Next-state, counter and flag computation; START low overrides everything.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_iter  = r_iter;
        w_nxt_done  = r_done;
        w_nxt_ovr   = r_ovr;
        w_launch    = 1'b0;
        if (!bus.START) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = CNT_ZERO;
            w_nxt_done  = 1'b0;
            w_nxt_ovr   = 1'b0;
        end else begin
            if (w_trig_edge && !bus.FREE_RUN && (r_state != S_IDLE) && (r_state != S_TRIG_WAIT)) begin
                w_nxt_ovr = 1'b1;
            end else begin
                w_nxt_ovr = r_ovr;
            end
            case (r_state)
                S_IDLE: begin
                    if (!r_done) begin
                        w_nxt_state = S_TRIG_WAIT;
                        w_nxt_iter  = ITER_ZERO;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end
                S_TRIG_WAIT: begin
                    if (bus.FREE_RUN || w_trig_edge) begin
                        w_launch = 1'b1;
                    end else begin
                        w_nxt_state = S_TRIG_WAIT;
                    end
                end
                S_PHASE_A: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_nxt_state = S_JP_WRT;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_JP_WRT: begin
                    // PHASE_B keeps one settling cycle beyond its programmed length
                    w_nxt_state = S_PHASE_B;
                    w_nxt_cnt   = r_len_b;
                end
                S_PHASE_B: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_nxt_state = S_JM_WRT;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_JM_WRT: begin
                    w_nxt_state = S_MATH;
                    w_nxt_cnt   = MATH_LOAD;
                end
                S_MATH: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_nxt_state = S_U_WRT;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_ONE;
                    end
                end
                S_U_WRT: begin
                    w_nxt_iter = w_iter_inc;
                    if ((bus.ITER_LIMIT != ITER_ZERO) && (w_iter_inc == bus.ITER_LIMIT)) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_done  = 1'b1;
                    end else if (bus.FREE_RUN) begin
                        w_launch = 1'b1;
                    end else begin
                        w_nxt_state = S_TRIG_WAIT;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                end
            endcase
            if (w_launch) begin
                w_nxt_state = S_PHASE_A;
                w_nxt_cnt   = (bus.PHASE_A_LEN == CNT_ZERO) ? CNT_ZERO : (bus.PHASE_A_LEN - CNT_ONE);
            end else begin
                w_nxt_state = w_nxt_state;
            end
        end
    end

    // State, counters, flags and Moore outputs registered from the next state.
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_len_b  <= CNT_ZERO;
            r_iter   <= ITER_ZERO;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_trig_d <= 1'b0;
            r_jp     <= 1'b0;
            r_jm     <= 1'b0;
            r_u      <= 1'b0;
            r_busy   <= 1'b0;
            r_dac    <= 2'b00;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_iter   <= w_nxt_iter;
            r_done   <= w_nxt_done;
            r_ovr    <= w_nxt_ovr;
            r_trig_d <= bus.TRIG_IN;
            if (w_launch) begin
                r_len_b <= (bus.PHASE_B_LEN == CNT_ZERO) ? CNT_ONE : bus.PHASE_B_LEN;
            end
            r_jp     <= (w_nxt_state == S_JP_WRT);
            r_jm     <= (w_nxt_state == S_JM_WRT);
            r_u      <= (w_nxt_state == S_U_WRT);
            r_busy   <= (w_nxt_state != S_IDLE);
            r_dac    <= dac_sel(w_nxt_state);
        end
    end

    assign bus.FSM_JP_WRT  = r_jp;
    assign bus.FSM_JM_WRT  = r_jm;
    assign bus.FSM_U_WRT   = r_u;
    assign bus.FSM_DAC_SEL = r_dac;
    assign bus.FSM_STATE   = r_state;
    assign bus.ITER_COUNT  = r_iter;
    assign bus.BUSY        = r_busy;
    assign bus.DONE        = r_done;
    assign bus.OVERRUN     = r_ovr;
endmodule

// File: tb/tb_spgd_sequencer.sv
// Bench for spgd_sequencer: directed timing scenarios plus a randomized run,
// all checked against an iteration-timeline reference model.
module tb_spgd_sequencer;
    localparam int MW = 5;

    logic ADC_CLK = 1'b0;
    logic RST_N   = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;

    spgd_sequencer_if #(.CNT_WIDTH(16), .ITER_WIDTH(16)) bus ();

    spgd_sequencer #(.CNT_WIDTH(16), .ITER_WIDTH(16), .MATH_WAIT_VALUE(MW)) dut (
        .ADC_CLK (ADC_CLK),
        .RST_N   (RST_N),
        .bus     (bus)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    // Reference model: mode 0 idle, 1 armed, 2 running at offset m_t into an iteration.
    int          m_mode;
    int          m_t;
    int          m_la;
    int          m_lb;
    logic [15:0] m_iter;
    logic        m_done;
    logic        m_ovr;
    logic        m_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_la = 1; m_lb = 1;
        m_iter = 16'd0; m_done = 1'b0; m_ovr = 1'b0; m_prev = 1'b0;
    endtask

    function automatic int u_at();
        return m_la + m_lb + MW + 3;
    endfunction

    task automatic start_iter(input int la, input int lb);
        m_mode = 2; m_t = 0;
        m_la = (la == 0) ? 1 : la;
        m_lb = (lb == 0) ? 1 : lb;
    endtask

    task automatic model_step(input logic s, input logic f, input logic t,
                              input int la, input int lb, input int lim);
        logic trig_edge;
        trig_edge = t && !m_prev;
        if (!s) begin
            m_mode = 0; m_done = 1'b0; m_ovr = 1'b0;
        end else begin
            case (m_mode)
                0: if (!m_done) begin m_mode = 1; m_iter = 16'd0; end
                1: if (f || trig_edge) start_iter(la, lb);
                default: begin
                    if (trig_edge && !f) m_ovr = 1'b1;
                    if (m_t == u_at()) begin
                        m_iter = m_iter + 16'd1;
                        if (lim != 0 && m_iter == 16'(lim)) begin
                            m_mode = 0; m_done = 1'b1;
                        end else if (f) begin
                            start_iter(la, lb);
                        end else begin
                            m_mode = 1;
                        end
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
        m_prev = t;
    endtask

    function automatic logic [31:0] exp_vec();
        logic [2:0] st;
        logic [1:0] dac;
        int pb_end;
        pb_end = m_la + m_lb + 2;
        if (m_mode == 0) begin
            st = 3'd0; dac = 2'b00;
        end else if (m_mode == 1) begin
            st = 3'd1; dac = 2'b11;
        end else begin
            if (m_t < m_la)        st = 3'd2;
            else if (m_t == m_la)  st = 3'd3;
            else if (m_t < pb_end) st = 3'd4;
            else if (m_t == pb_end) st = 3'd5;
            else if (m_t < u_at()) st = 3'd6;
            else                   st = 3'd7;
            dac = (m_t <= m_la) ? 2'b01 : 2'b10;
        end
        return {21'd0, st == 3'd3, st == 3'd5, st == 3'd7, dac, st, m_mode != 0, m_done, m_ovr};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {21'd0, bus.FSM_JP_WRT, bus.FSM_JM_WRT, bus.FSM_U_WRT, bus.FSM_DAC_SEL,
                bus.FSM_STATE, bus.BUSY, bus.DONE, bus.OVERRUN};
    endfunction

    task automatic step(input logic s, input logic f, input logic t,
                        input int la, input int lb, input int lim);
        bus.START = s; bus.FREE_RUN = f; bus.TRIG_IN = t;
        bus.PHASE_A_LEN = 16'(la); bus.PHASE_B_LEN = 16'(lb); bus.ITER_LIMIT = 16'(lim);
        model_step(s, f, t, la, lb, lim);
        @(posedge ADC_CLK);
        #1;
        cyc++;
        check_val("outs", dut_vec(), exp_vec());
        check_val("iter", 32'(bus.ITER_COUNT), 32'(m_iter));
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        #1;
        check_val("rst_outs", dut_vec(), 32'd0);
        check_val("rst_iter", 32'(bus.ITER_COUNT), 32'd0);
        model_reset();
        @(posedge ADC_CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        int k, jp_c, jm_c, u_c, n_u, it_before;
        int u_t[$];
        logic found, s, f, t;
        int la, lb, lim;

        bus.START = 1'b0; bus.FREE_RUN = 1'b0; bus.TRIG_IN = 1'b0;
        bus.PHASE_A_LEN = 16'd0; bus.PHASE_B_LEN = 16'd0; bus.ITER_LIMIT = 16'd0;
        model_reset();
        repeat (2) @(posedge ADC_CLK);
        #1;
        check_val("por_outs", dut_vec(), 32'd0);
        check_val("por_iter", 32'(bus.ITER_COUNT), 32'd0);
        RST_N = 1'b1;

        // Trigger latency with LA=4, LB=6, trigger held high for 50 cycles.
        step(1'b0, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b1, 4, 6, 0);
        k = cyc; jp_c = -1; jm_c = -1; u_c = -1; n_u = 0;
        for (int i = 0; i < 49; i++) begin
            step(1'b1, 1'b0, 1'b1, 4, 6, 0);
            if (bus.FSM_JP_WRT && jp_c < 0) jp_c = cyc;
            if (bus.FSM_JM_WRT && jm_c < 0) jm_c = cyc;
            if (bus.FSM_U_WRT && u_c < 0) u_c = cyc;
            if (bus.FSM_U_WRT) n_u++;
            if (cyc == k + 19) check_val("iter_after_u", 32'(bus.ITER_COUNT), 32'd1);
        end
        check_val("jp_latency", 32'(jp_c - k), 32'd4);
        check_val("jm_latency", 32'(jm_c - k), 32'd12);
        check_val("u_latency", 32'(u_c - k), 32'd18);
        check_val("held_trig_iters", 32'(n_u), 32'd1);
        step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b1, 4, 6, 0);
        check_val("retrigger_state", 32'(bus.FSM_STATE), 32'd2);

        // Reset in the middle of PHASE_B.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        check_val("in_phase_b", 32'(bus.FSM_STATE), 32'd4);
        pulse_reset();
        step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        check_val("post_rst_arm", 32'(bus.FSM_STATE), 32'd1);

        // Free-run with ITER_LIMIT=3, LA=LB=2.
        step(1'b0, 1'b0, 1'b0, 2, 2, 3);
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b1, 1'b0, 2, 2, 3);
            if (bus.FSM_U_WRT) u_t.push_back(cyc);
        end
        check_val("fr_u_count", 32'(u_t.size()), 32'd3);
        if (u_t.size() >= 3) begin
            check_val("fr_period1", 32'(u_t[1] - u_t[0]), 32'd13);
            check_val("fr_period2", 32'(u_t[2] - u_t[1]), 32'd13);
        end
        check_val("fr_done", 32'(bus.DONE), 32'd1);
        check_val("fr_idle", 32'(bus.FSM_STATE), 32'd0);

        // Trigger edge during PHASE_A sets OVERRUN; START low clears it.
        step(1'b0, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b1, 4, 6, 0);
        step(1'b1, 1'b0, 1'b0, 4, 6, 0);
        step(1'b1, 1'b0, 1'b1, 4, 6, 0);
        check_val("ovr_set", 32'(bus.OVERRUN), 32'd1);
        check_val("ovr_state", 32'(bus.FSM_STATE), 32'd2);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b1, 4, 6, 0);
        step(1'b0, 1'b0, 1'b0, 4, 6, 0);
        check_val("ovr_clear", 32'(bus.OVERRUN), 32'd0);

        // Abort during MATH: no U strobe, ITER_COUNT held.
        step(1'b1, 1'b0, 1'b0, 1, 1, 0);
        step(1'b1, 1'b0, 1'b1, 1, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 1'b1, 1, 1, 0);
            if (bus.FSM_STATE == 3'd6) found = 1'b1;
        end
        check_val("math_reach", 32'(found), 32'd1);
        it_before = int'(bus.ITER_COUNT);
        n_u = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 1, 1, 0);
            if (bus.FSM_U_WRT) n_u++;
        end
        check_val("abort_no_u", 32'(n_u), 32'd0);
        check_val("abort_idle", 32'(bus.FSM_STATE), 32'd0);
        check_val("abort_iter", 32'(bus.ITER_COUNT), 32'(it_before));

        // PHASE_A_LEN=0 behaves as one cycle.
        step(1'b1, 1'b0, 1'b0, 0, 3, 0);
        step(1'b1, 1'b0, 1'b1, 0, 3, 0);
        step(1'b1, 1'b0, 1'b1, 0, 3, 0);
        check_val("la0_jp", 32'(bus.FSM_JP_WRT), 32'd1);

        // Randomized run against the reference model.
        s = 1'b1; f = 1'b0; t = 1'b0; lim = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset();
            s = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 149) == 0) f = ~f;
            if ($urandom_range(0, 3) == 0) t = ~t;
            if ($urandom_range(0, 99) == 0) lim = int'($urandom_range(0, 3));
            la = int'($urandom_range(0, 4));
            lb = int'($urandom_range(0, 4));
            step(s, f, t, la, lb, lim);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
